// File: rtl/cla_pkg.sv
// Shared defaults and configuration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int CLA_BLK   = 4;

    function automatic int cla_nstg(input int width, input int blk);
        return width / blk;
    endfunction

    function automatic bit cla_cfg_ok(input int width, input int blk);
        return (blk > 0) && (width >= blk) && ((width % blk) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// One BLK-bit carry-lookahead slice: every carry is a flat sum-of-products of g/p/cin.
module cla_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           G,
    output logic           P
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;

    // Carry into bit i+1: any generate at j<=i propagated up through i, or cin through all.
    function automatic logic lookahead(input logic [BLK-1:0] gv, input logic [BLK-1:0] pv,
                                       input logic ci, input int i);
        logic acc;
        logic term;
        acc = ci;
        for (int j = 0; j <= i; j++) acc = acc & pv[j];
        for (int j = 0; j <= i; j++) begin
            term = gv[j];
            for (int m = j + 1; m <= i; m++) term = term & pv[m];
            acc = acc | term;
        end
        return acc;
    endfunction

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    for (genvar i = 0; i < BLK; i++) begin : g_carry
        assign c[i+1] = lookahead(g, p, cin, i);
    end

    assign s    = p ^ c[BLK-1:0];
    assign cout = c[BLK];
    assign G    = lookahead(g, p, 1'b0, BLK - 1);
    assign P    = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one BLK-bit block per stage, global-enable stall, last stage is the output register.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int BLK   = CLA_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_out,
    output logic             Overflow
);

    localparam int NSTG = cla_nstg(WIDTH, BLK);

    if (!cla_cfg_ok(WIDTH, BLK)) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be a positive multiple of BLK");
    end

    logic en;

    // Stage registers; operand copies ride along so later stages see their slice.
    logic [NSTG-1:0]            vld_q;
    logic [NSTG-1:0][WIDTH-1:0] a_q, b_q, sum_q;
    logic [NSTG-1:0]            c_q;
    logic                       ovf_q;

    // Per-stage inputs (from ports for stage 0, from the previous stage otherwise).
    logic [NSTG-1:0]            v_in;
    logic [NSTG-1:0][WIDTH-1:0] a_in, b_in, sum_in, sum_d;
    logic [NSTG-1:0]            c_in, c_d;
    logic [NSTG-1:0]            blk_g_unused, blk_p_unused;
    logic                       ovf_d;
    logic [WIDTH-1:0]           b_cond;
    logic                       unused_bits;

    assign en       = !vld_q[NSTG-1] || out_ready;
    assign in_ready = en;
    assign b_cond   = Sub ? ~B : B;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [BLK-1:0]   blk_s;
        logic [WIDTH-1:0] s_merged;

        if (k == 0) begin : g_head
            assign v_in[k]   = in_valid;
            assign a_in[k]   = A;
            assign b_in[k]   = b_cond;
            assign sum_in[k] = '0;
            assign c_in[k]   = Sub ? 1'b1 : Carry_in;
        end else begin : g_body
            assign v_in[k]   = vld_q[k-1];
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign sum_in[k] = sum_q[k-1];
            assign c_in[k]   = c_q[k-1];
        end

        cla_block #(.BLK(BLK)) u_blk (
            .a    (a_in[k][k*BLK +: BLK]),
            .b    (b_in[k][k*BLK +: BLK]),
            .cin  (c_in[k]),
            .s    (blk_s),
            .cout (c_d[k]),
            .G    (blk_g_unused[k]),
            .P    (blk_p_unused[k])
        );

        always_comb begin
            s_merged                = sum_in[k];
            s_merged[k*BLK +: BLK]  = blk_s;
        end
        assign sum_d[k] = s_merged;
    end

    assign ovf_d = (a_in[NSTG-1][WIDTH-1] == b_in[NSTG-1][WIDTH-1]) &&
                   (sum_d[NSTG-1][WIDTH-1] != a_in[NSTG-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            vld_q <= v_in;
            // Data only loads under a valid, so bubbles leave the last result intact.
            for (int k = 0; k < NSTG; k++) begin
                if (v_in[k]) begin
                    a_q[k]   <= a_in[k];
                    b_q[k]   <= b_in[k];
                    sum_q[k] <= sum_d[k];
                    c_q[k]   <= c_d[k];
                end
            end
            if (v_in[NSTG-1]) ovf_q <= ovf_d;
        end
    end

    assign out_valid = vld_q[NSTG-1];
    assign Sum       = sum_q[NSTG-1];
    assign Carry_out = c_q[NSTG-1];
    assign Overflow  = ovf_q;

    assign unused_bits = ^{a_q, b_q};

endmodule
